alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Two-requester scheduler that shares the single multi-cycle ALU between the control unit (port 0) and a second requester (port 1), e.g. the address/stack unit.
- Arbitrates round-robin and latches operands and opcode.
- Sequences the ALU start/done handshake, drives output-enable and carry-in, and captures result plus flags.
- Returns a one-cycle response to the granted requester. Sits between requesters and the ALU; the architectural flag register lives here.

Parameters:
- TIMEOUT, 64: max cycles spent in WAIT_BUSY or WAIT_DONE before the op aborts with err.
- MODE_LO, 8'h50: lowest mode-control opcode.
- MODE_HI, 8'h54: highest mode-control opcode.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  2  request per port; bit 0 = control unit, bit 1 = second requester.
- ir0, ir1  in  8  opcode per port.
- a0, b0, a1, b1  in  16  operands per port.
- gnt  out  2  one-cycle one-hot pulse; operands of the granted port are latched on this edge.
- rsp_valid  out  2  one-cycle one-hot response pulse to the owner port.
- rsp_result  out  16  captured result, held until the next capture.
- rsp_err  out  1  timeout abort; valid with rsp_valid.
- flags  out  5  {cmp, V, N, C, Z}.
- alu_start  out  1  one-cycle start pulse.
- alu_ir  out  8  latched opcode.
- alu_a, alu_b  out  16  latched operands.
- alu_oe  out  1  ALU output enable.
- alu_carryin  out  1  equals flags C.
- alu_done  in  1  ALU done level; high = idle.
- alu_out  in  16  ALU result.
- alu_carryout, alu_overout, alu_cmpo, alu_enable_flags  in  1  ALU status.

Behaviour:
- Reset values: state IDLE; gnt, rsp_valid, rsp_err, alu_start, alu_oe = 0; rsp_result, alu_ir, alu_a, alu_b = 0; flags = 0; last-grant pointer = 1, so port 0 wins the first tie.
- Reset mid-operation aborts with no response. ALU side outputs drop within the reset assertion.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE, MODE, RESPOND.
- IDLE, no req: stay in IDLE.
- IDLE, one req: grant that port.
- IDLE, both req: grant the port not granted last.
- On a grant, pulse gnt, latch ir/a/b and owner, and update the pointer.
  - Opcode in [MODE_LO, MODE_HI]: next state MODE.
  - Otherwise: next state ISSUE.
- ISSUE: alu_start=1 for exactly this cycle -> WAIT_BUSY; timeout counter cleared.
- WAIT_BUSY: wait for alu_done==0, then -> WAIT_DONE with counter cleared.
- WAIT_DONE: alu_oe=1. The sticky cmp capture is set if alu_cmpo==1 on any cycle here. On alu_done==1 -> CAPTURE.
- CAPTURE: alu_oe=1. Latch rsp_result=alu_out. If alu_enable_flags==1, update flags:
  - Z = (alu_out==0)
  - N = alu_out[15]
  - C = alu_carryout
  - V = alu_overout
  - cmp = sticky cmp capture
  If alu_enable_flags==0, flags are unchanged. Then -> RESPOND.
- MODE: no alu_start. Hold alu_ir for 2 cycles so the ALU idle logic decodes it; alu_done is ignored. Then -> RESPOND with rsp_result unchanged, flags unchanged, except opcode MODE_LO, which clears flags.cmp.
- RESPOND: rsp_valid[owner]=1, rsp_err as computed -> IDLE. No grant is issued in RESPOND. Minimum turnaround between grants is one IDLE cycle.
- Timeout: counter reaches TIMEOUT in WAIT_BUSY or WAIT_DONE -> RESPOND with rsp_err=1; flags and rsp_result unchanged.
- alu_ir, alu_a, alu_b are stable from the cycle after the grant until RESPOND completes.
- A requester dropping req after its grant does not cancel the op; the response is still delivered.
- req to the owner while busy is ignored until IDLE.
- alu_carryin always reflects flags C as registered before the current op.

Test Plan:
- Single op: port 0 req, ir0=8'h10, a0=16'h0003, b0=16'h0004; ALU model 4-cycle busy returning 16'h0007, carry 0 -> gnt=01 one cycle; alu_start one cycle later; rsp_valid=01, rsp_result=16'h0007, flags Z=0 N=0 C=0.
- Contention: req=11 held for 4 ops -> grants alternate 01,10,01,10. After reset, first tie grants 01.
- Flags: model returns 16'h0000 with carryout=1, enable_flags=1 -> Z=1, C=1. Next op sees alu_carryin=1. Repeat with enable_flags=0 -> flags unchanged.
- Mode op: ir0=8'h52 -> no alu_start; rsp_valid after 2 MODE cycles; result unchanged. ir0=8'h50 after a cmp op -> flags.cmp cleared.
- Timeout: model never drops alu_done -> rsp_err=1 after TIMEOUT cycles in WAIT_BUSY; flags and result unchanged; next op proceeds normally.
- Reset mid-op: assert rst during WAIT_DONE -> all outputs 0 asynchronously, no rsp_valid. After release, req=10 is granted.

Source files
------------

// File: rtl/alu_sched.sv
// alu_sched: shares one multi-cycle ALU between two requesters.
//   Round-robin arbitration, operand/opcode latching, ALU start/done sequencing,
//   result and flag capture, one-cycle response back to the granted port.
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   req[1:0]                   request per port (bit 0 control unit, bit 1 second requester)
//   ir0/ir1, a0/b0, a1/b1      opcode and operands per port
//   gnt[1:0]                   one-hot grant pulse; operands latched on the same edge
//   rsp_valid[1:0]             one-hot response pulse to the owner port
//   rsp_result, rsp_err        captured result (held), timeout abort flag
//   flags[4:0]                 architectural flags {cmp, V, N, C, Z}
//   alu_start, alu_ir, alu_a, alu_b, alu_oe, alu_carryin   ALU drive side
//   alu_done, alu_out, alu_carryout, alu_overout, alu_cmpo, alu_enable_flags   ALU status
module alu_sched #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [7:0]  MODE_LO = 8'h50,
  parameter logic [7:0]  MODE_HI = 8'h54
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [7:0]  ir0,
  input  logic [7:0]  ir1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic [1:0]  gnt,
  output logic [1:0]  rsp_valid,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic [4:0]  flags,
  output logic        alu_start,
  output logic [7:0]  alu_ir,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_oe,
  output logic        alu_carryin,
  input  logic        alu_done,
  input  logic [15:0] alu_out,
  input  logic        alu_carryout,
  input  logic        alu_overout,
  input  logic        alu_cmpo,
  input  logic        alu_enable_flags
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StCapture,
    StMode,
    StRespond
  } state_e;

  state_e          state_q;
  logic            owner_q;
  logic            last_q;   // port granted most recently
  logic            cmp_q;    // sticky alu_cmpo seen during WAIT_DONE
  logic [CntW-1:0] cnt_q;    // timeout counter, also MODE cycle counter

  logic       grant_port;
  logic [7:0] sel_ir;
  logic       sel_is_mode;
  logic [1:0] owner_onehot;

  always_comb begin
    grant_port = 1'b0;
    case (req)
      2'b10:   grant_port = 1'b1;
      2'b11:   grant_port = ~last_q;
      default: grant_port = 1'b0;
    endcase
  end

  assign sel_ir       = grant_port ? ir1 : ir0;
  assign sel_is_mode  = (sel_ir >= MODE_LO) && (sel_ir <= MODE_HI);
  assign owner_onehot = owner_q ? 2'b10 : 2'b01;
  assign alu_carryin  = flags[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      cmp_q      <= 1'b0;
      cnt_q      <= '0;
      gnt        <= 2'b00;
      rsp_valid  <= 2'b00;
      rsp_err    <= 1'b0;
      rsp_result <= 16'h0000;
      flags      <= 5'b00000;
      alu_start  <= 1'b0;
      alu_ir     <= 8'h00;
      alu_a      <= 16'h0000;
      alu_b      <= 16'h0000;
      alu_oe     <= 1'b0;
    end else begin
      // Pulse outputs default low; each state raises them for a single cycle.
      gnt       <= 2'b00;
      rsp_valid <= 2'b00;
      rsp_err   <= 1'b0;
      alu_start <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|req) begin
            gnt     <= grant_port ? 2'b10 : 2'b01;
            owner_q <= grant_port;
            last_q  <= grant_port;
            alu_ir  <= sel_ir;
            alu_a   <= grant_port ? a1 : a0;
            alu_b   <= grant_port ? b1 : b0;
            cmp_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= sel_is_mode ? StMode : StIssue;
          end
        end
        StIssue: begin
          alu_start <= 1'b1;
          cnt_q     <= '0;
          state_q   <= StWaitBusy;
        end
        StWaitBusy: begin
          if (!alu_done) begin
            cnt_q   <= '0;
            alu_oe  <= 1'b1;
            state_q <= StWaitDone;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            rsp_valid <= owner_onehot;
            rsp_err   <= 1'b1;
            state_q   <= StRespond;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitDone: begin
          if (alu_cmpo) begin
            cmp_q <= 1'b1;
          end
          if (alu_done) begin
            state_q <= StCapture;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            alu_oe    <= 1'b0;
            rsp_valid <= owner_onehot;
            rsp_err   <= 1'b1;
            state_q   <= StRespond;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StCapture: begin
          rsp_result <= alu_out;
          if (alu_enable_flags) begin
            flags <= {cmp_q, alu_overout, alu_out[15], alu_carryout, (alu_out == 16'h0000)};
          end
          alu_oe    <= 1'b0;
          rsp_valid <= owner_onehot;
          state_q   <= StRespond;
        end
        StMode: begin
          // Opcode is held two cycles for the ALU idle decoder; alu_done is not consulted.
          if (cnt_q != '0) begin
            if (alu_ir == MODE_LO) begin
              flags[4] <= 1'b0;
            end
            rsp_valid <= owner_onehot;
            state_q   <= StRespond;
          end else begin
            cnt_q <= CntW'(1);
          end
        end
        StRespond: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed scenarios followed by random
// transactions, all checked against a transaction-level reference model.
module tb_alu_sched;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [7:0]  ir0, ir1;
  logic [15:0] a0, b0, a1, b1;
  logic [1:0]  gnt, rsp_valid;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic [4:0]  flags;
  logic        alu_start, alu_oe, alu_carryin;
  logic [7:0]  alu_ir;
  logic [15:0] alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_out;
  logic        alu_carryout, alu_overout, alu_cmpo, alu_enable_flags;

  // ALU model knobs
  int unsigned cfg_lat;
  logic        cfg_hang, cfg_cmp, cfg_cout, cfg_vout, cfg_en;
  logic [15:0] cfg_out;
  int unsigned busy_left;

  // Reference model state
  logic [4:0]  m_flags;
  logic [15:0] m_result;
  logic        m_last;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  alu_sched #(
    .TIMEOUT (TO),
    .MODE_LO (8'h50),
    .MODE_HI (8'h54)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .ir0              (ir0),
    .ir1              (ir1),
    .a0               (a0),
    .b0               (b0),
    .a1               (a1),
    .b1               (b1),
    .gnt              (gnt),
    .rsp_valid        (rsp_valid),
    .rsp_result       (rsp_result),
    .rsp_err          (rsp_err),
    .flags            (flags),
    .alu_start        (alu_start),
    .alu_ir           (alu_ir),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_oe           (alu_oe),
    .alu_carryin      (alu_carryin),
    .alu_done         (alu_done),
    .alu_out          (alu_out),
    .alu_carryout     (alu_carryout),
    .alu_overout      (alu_overout),
    .alu_cmpo         (alu_cmpo),
    .alu_enable_flags (alu_enable_flags)
  );

  // ALU: after a start, alu_done stays low for cfg_lat cycles; a hung ALU never starts.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_done  <= 1'b1;
      busy_left <= 0;
    end else if (alu_start && !cfg_hang) begin
      alu_done  <= 1'b0;
      busy_left <= cfg_lat;
    end else if (!alu_done) begin
      if (busy_left == 1) alu_done <= 1'b1;
      busy_left <= busy_left - 1;
    end
  end

  assign alu_out          = cfg_out;
  assign alu_carryout     = cfg_cout;
  assign alu_overout      = cfg_vout;
  assign alu_enable_flags = cfg_en;
  assign alu_cmpo         = cfg_cmp & ~alu_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_alu(input int unsigned lat, input logic [15:0] out, input logic cout,
                         input logic vout, input logic cmp, input logic en, input logic hang);
    cfg_lat = lat; cfg_out = out; cfg_cout = cout; cfg_vout = vout;
    cfg_cmp = cmp; cfg_en = en; cfg_hang = hang;
  endtask

  // One full transaction; called with the DUT idle, at a falling edge.
  task automatic run_op(input logic [1:0] rq, input logic [7:0] i0, input logic [7:0] i1,
                        input logic [15:0] x0, input logic [15:0] y0,
                        input logic [15:0] x1, input logic [15:0] y1);
    logic        p;
    logic [7:0]  op;
    logic [15:0] ea, eb, er;
    logic [4:0]  ef;
    logic        ee, is_mode, stable, extra, saw_oe;
    int          n_start, t_start, c;

    p       = (rq == 2'b11) ? ~m_last : rq[1];
    op      = p ? i1 : i0;
    ea      = p ? x1 : x0;
    eb      = p ? y1 : y0;
    is_mode = (op >= 8'h50) && (op <= 8'h54);

    if (is_mode) begin
      er = m_result; ee = 1'b0; ef = m_flags;
      if (op == 8'h50) ef[4] = 1'b0;
    end else if (cfg_hang) begin
      er = m_result; ee = 1'b1; ef = m_flags;
    end else begin
      er = cfg_out; ee = 1'b0;
      ef = cfg_en ? {cfg_cmp, cfg_vout, cfg_out[15], cfg_cout, cfg_out == 16'h0000} : m_flags;
    end

    req = rq; ir0 = i0; ir1 = i1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (gnt != 2'b00) break;
    end
    check_eq("gnt", 32'(gnt), p ? 32'd2 : 32'd1);
    check_eq("carryin", 32'(alu_carryin), 32'(m_flags[1]));
    m_last = p;

    n_start = 0; t_start = -1; stable = 1'b1; extra = 1'b0; saw_oe = 1'b0;
    for (c = 1; c <= int'(TO) + 40; c++) begin
      req = 2'($urandom);
      @(negedge clk);
      if (alu_start) begin n_start++; t_start = c; end
      if (gnt != 2'b00) extra = 1'b1;
      if (alu_oe) saw_oe = 1'b1;
      if ({alu_ir, alu_a, alu_b} !== {op, ea, eb}) stable = 1'b0;
      if (rsp_valid != 2'b00) break;
    end

    check_eq("rsp_valid", 32'(rsp_valid), p ? 32'd2 : 32'd1);
    check_eq("rsp_err", 32'(rsp_err), 32'(ee));
    check_eq("rsp_result", 32'(rsp_result), 32'(er));
    check_eq("flags", 32'(flags), 32'(ef));
    check_eq("operands_stable", 32'(stable), 32'd1);
    check_eq("no_regrant", 32'(extra), 32'd0);
    check_eq("start_count", 32'(n_start), is_mode ? 32'd0 : 32'd1);
    if (!is_mode) check_eq("start_delay", 32'(t_start), 32'd1);
    check_eq("oe_seen", 32'(saw_oe), 32'(!is_mode && !cfg_hang));
    if (is_mode) check_eq("mode_latency", 32'(c), 32'd2);
    else if (cfg_hang) check_eq("timeout_latency", 32'(c), 32'(TO + 1));

    // No grant may be issued straight out of RESPOND.
    req = 2'b11;
    @(negedge clk);
    check_eq("turnaround", 32'(gnt), 32'd0);
    req = 2'b00;

    m_result = er;
    m_flags  = ef;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; req = 2'b00;
    ir0 = 8'h00; ir1 = 8'h00; a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0;
    set_alu(4, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    m_flags = 5'b0; m_result = 16'h0; m_last = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_ctrl", 32'({gnt, rsp_valid, rsp_err, alu_start, alu_oe, flags, alu_carryin}),
             32'd0);
    check_eq("reset_res_ir", 32'({rsp_result, alu_ir}), 32'd0);
    check_eq("reset_ab", {alu_a, alu_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // First tie after reset goes to port 0, then a plain port-0 op.
    run_op(2'b11, 8'h10, 8'h20, 16'h0003, 16'h0004, 16'h0005, 16'h0006);
    run_op(2'b01, 8'h10, 8'h20, 16'h0003, 16'h0004, 16'h0005, 16'h0006);
    // Sustained contention alternates.
    for (int i = 0; i < 4; i++)
      run_op(2'b11, 8'h11, 8'h21, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));

    // Zero result with carry sets Z and C; next op sees carryin; disabled flags hold.
    set_alu(3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(2'b01, 8'h12, 8'h00, 16'h1, 16'h2, 16'h0, 16'h0);
    set_alu(3, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(2'b01, 8'h13, 8'h00, 16'h1, 16'h2, 16'h0, 16'h0);

    // Compare op sets cmp; mode 52 keeps it; mode 50 clears it.
    set_alu(3, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op(2'b01, 8'h14, 8'h00, 16'h7, 16'h7, 16'h0, 16'h0);
    run_op(2'b01, 8'h52, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0);
    run_op(2'b01, 8'h50, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0);

    // Hung ALU times out; the next op proceeds.
    set_alu(3, 16'hdead, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    run_op(2'b10, 8'h00, 8'h15, 16'h0, 16'h0, 16'h9, 16'h9);
    set_alu(2, 16'h4242, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(2'b10, 8'h00, 8'h16, 16'h0, 16'h0, 16'h9, 16'h9);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] o0, o1;
      o0 = ($urandom_range(0, 3) == 0) ? 8'(8'h50 + $urandom_range(0, 4)) : 8'($urandom);
      o1 = ($urandom_range(0, 3) == 0) ? 8'(8'h50 + $urandom_range(0, 4)) : 8'($urandom);
      set_alu($urandom_range(2, 6), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), $urandom_range(0, 7) == 0);
      run_op(2'($urandom_range(1, 3)), o0, o1, 16'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom));
    end

    // Reset during WAIT_DONE: outputs clear at once, no response follows.
    set_alu(6, 16'hbeef, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    req = 2'b01; ir0 = 8'h17; a0 = 16'h1111; b0 = 16'h2222;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req = 2'b00;
      if (alu_oe) begin seen = 1'b1; break; end
    end
    check_eq("reach_wait_done", 32'(seen), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("midop_ctrl", 32'({gnt, rsp_valid, rsp_err, alu_start, alu_oe, flags, alu_carryin}),
             32'd0);
    check_eq("midop_res_ir", 32'({rsp_result, alu_ir}), 32'd0);
    check_eq("midop_ab", {alu_a, alu_b}, 32'd0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    check_eq("no_rsp_after_reset", 32'(seen), 32'd0);
    m_flags = 5'b0; m_result = 16'h0; m_last = 1'b1;
    set_alu(3, 16'h0055, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(2'b10, 8'h00, 8'h18, 16'h0, 16'h0, 16'h3, 16'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
